// File: rtl/snake_game_ctrl_if.sv
// Bundle of control inputs and phase/status outputs between snake_game_ctrl and its peers.
interface snake_game_ctrl_if #(
  parameter int unsigned DELAY_W = 32,
  parameter int unsigned SCORE_W = 8,
  parameter int unsigned LEVEL_W = 4
);
  logic               setup_done;
  logic [1:0]         move_result;
  logic               pause;
  logic               replay;
  logic               setup_go;
  logic               move_go;
  logic               spawn_go;
  logic               delay_go;
  logic               pause_go;
  logic               lose_go;
  logic [SCORE_W-1:0] score;
  logic [LEVEL_W-1:0] level;
  logic [DELAY_W-1:0] cur_delay;

  modport master (
    output setup_done, move_result, pause, replay,
    input  setup_go, move_go, spawn_go, delay_go, pause_go, lose_go,
    input  score, level, cur_delay
  );

  modport slave (
    input  setup_done, move_result, pause, replay,
    output setup_go, move_go, spawn_go, delay_go, pause_go, lose_go,
    output score, level, cur_delay
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: setup/move/spawn/delay/pause/lose phases, move-delay timer,
// score and level tracking with a per-level shrinking delay.
module snake_game_ctrl #(
  parameter int unsigned BASE_DELAY      = 50_000_000,
  parameter int unsigned MIN_DELAY       = 5_000_000,
  parameter int unsigned DELAY_STEP      = 5_000_000,
  parameter int unsigned DELAY_W         = 32,
  parameter int unsigned FOODS_PER_LEVEL = 5,
  parameter int unsigned SCORE_W         = 8,
  parameter int unsigned LEVEL_W         = 4
) (
  input  logic            clk,
  input  logic            reset,
  snake_game_ctrl_if.slave bus
);

  localparam int unsigned FOOD_W = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;
  localparam logic [FOOD_W-1:0]  FOOD_LAST = FOOD_W'(FOODS_PER_LEVEL - 1);
  localparam logic [DELAY_W-1:0] BASE_D    = DELAY_W'(BASE_DELAY);
  localparam logic [DELAY_W-1:0] MIN_D     = DELAY_W'(MIN_DELAY);
  localparam logic [DELAY_W-1:0] STEP_D    = DELAY_W'(DELAY_STEP);
  // Extra bit so MIN+STEP cannot overflow; stepping is allowed only at or above it.
  localparam logic [DELAY_W:0]   STEP_THR  = (DELAY_W+1)'(MIN_DELAY) + (DELAY_W+1)'(DELAY_STEP);

  typedef enum logic [2:0] {
    S_SETUP = 3'd0,
    S_MOVE  = 3'd1,
    S_SPAWN = 3'd2,
    S_DELAY = 3'd3,
    S_PAUSE = 3'd4,
    S_LOSE  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         go_q;
  logic [SCORE_W-1:0] score_q;
  logic [LEVEL_W-1:0] level_q;
  logic [FOOD_W-1:0]  food_q;
  logic [DELAY_W-1:0] cnt_q;
  logic [DELAY_W-1:0] cur_delay_q;
  logic               delay_last;

  assign delay_last = (cnt_q == cur_delay_q - DELAY_W'(1));

  // Next phase
  always_comb begin
    state_d = S_SETUP;
    case (state_q)
      S_SETUP: state_d = bus.setup_done ? S_MOVE : S_SETUP;
      S_MOVE: begin
        case (bus.move_result)
          2'b01:   state_d = S_DELAY;
          2'b10:   state_d = S_SPAWN;
          2'b11:   state_d = S_LOSE;
          default: state_d = S_MOVE;
        endcase
      end
      S_SPAWN: state_d = S_DELAY;
      S_DELAY: state_d = bus.pause ? S_PAUSE : (delay_last ? S_MOVE : S_DELAY);
      S_PAUSE: state_d = bus.pause ? S_PAUSE : S_DELAY;
      S_LOSE:  state_d = bus.replay ? S_SETUP : S_LOSE;
      default: state_d = S_SETUP;
    endcase
  end

  // Phase register, one-hot flags and game datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SETUP;
      go_q        <= 6'b000001;
      score_q     <= '0;
      level_q     <= '0;
      food_q      <= '0;
      cnt_q       <= '0;
      cur_delay_q <= BASE_D;
    end else begin
      state_q <= state_d;
      go_q    <= 6'b000001 << 3'(state_d);
      case (state_q)
        S_SETUP: begin
          score_q     <= '0;
          level_q     <= '0;
          food_q      <= '0;
          cur_delay_q <= BASE_D;
        end
        S_MOVE: begin
          cnt_q <= '0;
          if (bus.move_result == 2'b10 && score_q != '1) begin
            score_q <= score_q + SCORE_W'(1);
          end
        end
        S_SPAWN: begin
          cnt_q <= '0;
          if (food_q == FOOD_LAST) begin
            food_q <= '0;
            if (level_q != '1) begin
              level_q <= level_q + LEVEL_W'(1);
            end
            cur_delay_q <= ({1'b0, cur_delay_q} >= STEP_THR) ? (cur_delay_q - STEP_D) : MIN_D;
          end else begin
            food_q <= food_q + FOOD_W'(1);
          end
        end
        S_DELAY: begin
          if (!bus.pause && !delay_last) begin
            cnt_q <= cnt_q + DELAY_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.setup_go  = go_q[0];
  assign bus.move_go   = go_q[1];
  assign bus.spawn_go  = go_q[2];
  assign bus.delay_go  = go_q[3];
  assign bus.pause_go  = go_q[4];
  assign bus.lose_go   = go_q[5];
  assign bus.score     = score_q;
  assign bus.level     = level_q;
  assign bus.cur_delay = cur_delay_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed vector table, corner sequences, and random
// stimulus checked against a phase-level reference model.
module tb_snake_game_ctrl;

  localparam int BASE = 4, MIND = 2, STEP = 1, FPL = 2, SW = 3, LW = 2, DW = 8;
  localparam int SMAX = (1 << SW) - 1, LMAX = (1 << LW) - 1;
  localparam logic [5:0] G_SETUP = 6'b000001, G_MOVE = 6'b000010, G_SPAWN = 6'b000100,
                         G_DELAY = 6'b001000, G_PAUSE = 6'b010000, G_LOSE = 6'b100000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  snake_game_ctrl_if #(.DELAY_W(DW), .SCORE_W(SW), .LEVEL_W(LW)) bus();

  snake_game_ctrl #(
    .BASE_DELAY(BASE), .MIN_DELAY(MIND), .DELAY_STEP(STEP), .DELAY_W(DW),
    .FOODS_PER_LEVEL(FPL), .SCORE_W(SW), .LEVEL_W(LW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [5:0] go;
  assign go = {bus.lose_go, bus.pause_go, bus.delay_go, bus.spawn_go, bus.move_go, bus.setup_go};

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  // Reference model: phase 0..5 = setup, move, spawn, delay, pause, lose.
  // Level-ups are derived from the number of completed spawns.
  int m_ph = 0, m_eaten = 0, m_spawns = 0, m_rem = 0;
  bit m_valid = 1'b0;

  function automatic int exp_delay(input int spawns);
    return imax(BASE - (spawns / FPL) * STEP, MIND);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ph <= 0; m_eaten <= 0; m_spawns <= 0; m_rem <= 0; m_valid <= 1'b1;
    end else begin
      case (m_ph)
        0: begin
          m_eaten <= 0; m_spawns <= 0;
          if (bus.setup_done) m_ph <= 1;
        end
        1: begin
          if (bus.move_result == 2'b01) begin m_ph <= 3; m_rem <= exp_delay(m_spawns); end
          else if (bus.move_result == 2'b10) begin m_ph <= 2; m_eaten <= m_eaten + 1; end
          else if (bus.move_result == 2'b11) m_ph <= 5;
        end
        2: begin
          m_spawns <= m_spawns + 1; m_ph <= 3; m_rem <= exp_delay(m_spawns + 1);
        end
        3: begin
          if (bus.pause) m_ph <= 4;
          else if (m_rem == 1) m_ph <= 1;
          else m_rem <= m_rem - 1;
        end
        4: if (!bus.pause) m_ph <= 3;
        default: if (bus.replay) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model.go", go, longint'(1) << m_ph);
      check("model.score", bus.score, imin(m_eaten, SMAX));
      check("model.level", bus.level, imin(m_spawns / FPL, LMAX));
      check("model.cur_delay", bus.cur_delay, exp_delay(m_spawns));
    end
  end

  typedef struct {
    logic       rst, sd;
    logic [1:0] mr;
    logic       pz, rp;
    logic [5:0] g;
    int         sc, lv, dl;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic rst, input logic sd, input logic [1:0] mr, input logic pz,
                     input logic rp, input logic [5:0] g, input int sc, input int lv, input int dl);
    vec_t v;
    v.rst = rst; v.sd = sd; v.mr = mr; v.pz = pz; v.rp = rp;
    v.g = g; v.sc = sc; v.lv = lv; v.dl = dl;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starting in MOVE: eat the k-th food and follow SPAWN, DELAY back to MOVE.
  task automatic eat_food(input int k);
    int n;
    bus.move_result = 2'b10;
    step();
    check("food.spawn_go", go, G_SPAWN);
    check("food.score", bus.score, imin(k, SMAX));
    check("food.level_in_spawn", bus.level, imin((k - 1) / FPL, LMAX));
    bus.move_result = 2'b00;
    step();
    check("food.delay_go", go, G_DELAY);
    check("food.level", bus.level, imin(k / FPL, LMAX));
    check("food.cur_delay", bus.cur_delay, imax(BASE - (k / FPL) * STEP, MIND));
    n = 0;
    while (bus.delay_go && n < 20) begin
      n++;
      step();
    end
    check("food.delay_len", n, imax(BASE - (k / FPL) * STEP, MIND));
    check("food.back_to_move", go, G_MOVE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.setup_done = 1'b0; bus.move_result = 2'b00; bus.pause = 1'b0; bus.replay = 1'b0;

    // Reset, setup, one plain move, one food, then a pause in the third DELAY cycle.
    add(1, 0, 2'd0, 0, 0, G_SETUP, 0, 0, 4);
    add(0, 0, 2'd0, 0, 0, G_SETUP, 0, 0, 4);
    add(0, 1, 2'd0, 0, 0, G_MOVE,  0, 0, 4);
    add(0, 0, 2'd1, 0, 0, G_DELAY, 0, 0, 4);
    repeat (3) add(0, 0, 2'd0, 0, 0, G_DELAY, 0, 0, 4);
    add(0, 0, 2'd0, 0, 0, G_MOVE,  0, 0, 4);
    add(0, 0, 2'd2, 0, 0, G_SPAWN, 1, 0, 4);
    repeat (3) add(0, 0, 2'd0, 0, 0, G_DELAY, 1, 0, 4);
    repeat (5) add(0, 0, 2'd0, 1, 0, G_PAUSE, 1, 0, 4);
    repeat (2) add(0, 0, 2'd0, 0, 0, G_DELAY, 1, 0, 4);
    add(0, 0, 2'd0, 0, 0, G_MOVE,  1, 0, 4);
    repeat (2) add(0, 0, 2'd0, 1, 1, G_MOVE, 1, 0, 4);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; bus.setup_done = vecs[i].sd; bus.move_result = vecs[i].mr;
      bus.pause = vecs[i].pz; bus.replay = vecs[i].rp;
      step();
      check($sformatf("vec%0d.go", i), go, vecs[i].g);
      check($sformatf("vec%0d.score", i), bus.score, vecs[i].sc);
      check($sformatf("vec%0d.level", i), bus.level, vecs[i].lv);
      check($sformatf("vec%0d.cur_delay", i), bus.cur_delay, vecs[i].dl);
    end

    // Reset while paused.
    bus.pause = 1'b0; bus.replay = 1'b0; bus.move_result = 2'b01;
    step();
    check("rstpause.delay", go, G_DELAY);
    bus.move_result = 2'b00; bus.pause = 1'b1;
    step();
    check("rstpause.pause", go, G_PAUSE);
    reset = 1'b1;
    step();
    check("rstpause.setup", go, G_SETUP);
    check("rstpause.score", bus.score, 0);
    check("rstpause.cur_delay", bus.cur_delay, BASE);
    reset = 1'b0;
    repeat (3) begin
      step();
      check("rstpause.stay_setup", go, G_SETUP);
    end
    bus.pause = 1'b0;

    // Nine foods: level-ups, delay floor, score and level saturation.
    bus.setup_done = 1'b1;
    step();
    check("foods.move", go, G_MOVE);
    bus.setup_done = 1'b0;
    for (int k = 1; k <= 9; k++) eat_food(k);

    // Collision, LOSE holds the score, replay returns to SETUP which clears it.
    bus.move_result = 2'b11;
    step();
    check("lose.enter", go, G_LOSE);
    bus.move_result = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step();
      check("lose.hold", go, G_LOSE);
      check("lose.score", bus.score, SMAX);
      check("lose.level", bus.level, LMAX);
    end
    bus.replay = 1'b1;
    step();
    check("replay.setup", go, G_SETUP);
    bus.replay = 1'b0;
    step();
    check("replay.setup2", go, G_SETUP);
    check("replay.score", bus.score, 0);
    check("replay.level", bus.level, 0);
    check("replay.cur_delay", bus.cur_delay, BASE);

    // Random stimulus, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      bus.setup_done = ($urandom_range(0, 3) == 0);
      bus.move_result = 2'($urandom_range(0, 3));
      bus.pause = ($urandom_range(0, 4) == 0);
      bus.replay = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
